// File: rtl/clk_period_monitor.sv
// clk_period_monitor
// Measures the period of an asynchronous clock (mon_clk) in units of the local clk,
// tracks lock status against a programmable [min_period, max_period] window and flags
// out-of-range and stopped-clock conditions with sticky error bits.
// Optional feature macro: CLK_PERIOD_MONITOR_DUTY_EN builds the high-time counter.
// Without it, high_time is tied to zero.
module clk_period_monitor #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 4,
   parameter int TIMEOUT     = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mon_clk,
   input  logic             enable,
   input  logic [CNT_W-1:0] min_period,
   input  logic [CNT_W-1:0] max_period,
   input  logic             clear_err,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic [CNT_W-1:0] high_time,
   output logic             locked,
   output logic             err_range,
   output logic             err_stopped,
   output logic [31:0]      edge_count
);

   localparam int               LOCK_W     = $clog2(LOCK_COUNT + 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);
   // cnt is about to reach TIMEOUT on this edge
   localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      STOPPED = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [SYNC_STAGES-1:0]  sync_ff;
   logic                    delay;
   logic                    sync;
   logic                    rise;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        period_calc;
   logic [LOCK_W-1:0]       lock_cnt;
   logic [LOCK_W-1:0]       lock_inc;
   logic                    in_range;
   logic                    timeout_reach;
   logic                    report;
   logic                    stop_event;
   logic                    range_set;
   logic                    stopped_set;

   assign sync          = sync_ff[SYNC_STAGES-1];
   assign rise          = sync & ~delay;
   assign period_calc   = cnt + CNT_W'(1);
   // Inclusive window; min_period > max_period makes every period fail.
   assign in_range      = (period_calc >= min_period) && (period_calc <= max_period);
   // A rise on the same edge as the timeout takes priority over the timeout.
   assign timeout_reach = (cnt == TIMEOUT_M1);
   assign report        = enable && (state == MEASURE) && rise;
   assign stop_event    = enable && ((state == ARM) || (state == MEASURE)) && !rise && timeout_reach;
   assign range_set     = report && !in_range;
   assign stopped_set   = stop_event || (enable && (state == STOPPED));
   assign lock_inc      = (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + LOCK_W'(1);

   // Synchronize mon_clk into clk domain and keep one delayed copy for edge detection.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
         delay   <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], mon_clk};
         delay   <= sync;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; enable low forces a return to IDLE from any state.
   // NOTE: state_next is defaulted first so no path through this block infers a latch.
   always_comb begin
      state_next = state;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = ARM;
            ARM: begin
               if (rise)               state_next = MEASURE;
               else if (timeout_reach) state_next = STOPPED;
            end
            MEASURE: if (!rise && timeout_reach) state_next = STOPPED;
            STOPPED: if (rise) state_next = MEASURE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Cycles since the last rise, saturating at TIMEOUT; held at zero while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!enable || (state == IDLE)) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= '0;
      end else if (cnt != TIMEOUT_V) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Period report and edge counter; edge_count restarts when leaving IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period     <= '0;
         period_vld <= 1'b0;
         edge_count <= '0;
      end else begin
         period_vld <= report;
         if (report) begin
            period     <= period_calc;
            edge_count <= edge_count + 32'd1;
         end else if (enable && (state == IDLE)) begin
            edge_count <= '0;
         end
      end
   end

   // Lock tracking: consecutive in-range periods while measuring.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (!enable || (state != MEASURE) || stop_event) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (report) begin
         if (in_range) begin
            lock_cnt <= lock_inc;
            locked   <= (lock_inc == LOCK_MAX);
         end else begin
            lock_cnt <= '0;
            locked   <= 1'b0;
         end
      end
   end

   // Sticky errors; a new error on the same edge as clear_err wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_range   <= 1'b0;
         err_stopped <= 1'b0;
      end else begin
         if (range_set)      err_range <= 1'b1;
         else if (clear_err) err_range <= 1'b0;
         if (stopped_set)      err_stopped <= 1'b1;
         else if (clear_err)   err_stopped <= 1'b0;
      end
   end

`ifdef CLK_PERIOD_MONITOR_DUTY_EN
   logic [CNT_W-1:0] hcnt;

   // High-time counter; the rise cycle itself is high, so it is added at report time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt      <= '0;
         high_time <= '0;
      end else begin
         if (report) high_time <= hcnt + CNT_W'(1);
         if (rise)                   hcnt <= '0;
         else if (sync && (hcnt != '1)) hcnt <= hcnt + CNT_W'(1);
      end
   end
`else
   assign high_time = '0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb_clk_period_monitor
// Directed bench for clk_period_monitor. mon_clk is generated on clk falling edges
// with a programmable period/high time (in clk cycles); new settings take effect at
// the next mon_clk rising edge. Outputs are sampled 1ns after the clk rising edge.
module tb_clk_period_monitor;

   localparam int CNT_W = 16;
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
   localparam int HT50 = 2;
   localparam int HT25 = 1;
`else
   localparam int HT50 = 0;
   localparam int HT25 = 0;
`endif

   logic             clk        = 1'b0;
   logic             rst_n      = 1'b0;
   logic             mon_clk    = 1'b0;
   logic             enable     = 1'b0;
   logic             clear_err  = 1'b0;
   logic [CNT_W-1:0] min_period = 16'd3;
   logic [CNT_W-1:0] max_period = 16'd5;
   logic [CNT_W-1:0] period;
   logic             period_vld;
   logic [CNT_W-1:0] high_time;
   logic             locked;
   logic             err_range;
   logic             err_stopped;
   logic [31:0]      edge_count;

   int n_vec   = 0;
   int n_err   = 0;
   bit mon_run = 1'b0;
   int mon_per = 4;
   int mon_hi  = 2;
   int cur_per = 4;
   int cur_hi  = 2;
   int phase   = 0;
   int cyc;

   clk_period_monitor dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mon_clk     (mon_clk),
      .enable      (enable),
      .min_period  (min_period),
      .max_period  (max_period),
      .clear_err   (clear_err),
      .period      (period),
      .period_vld  (period_vld),
      .high_time   (high_time),
      .locked      (locked),
      .err_range   (err_range),
      .err_stopped (err_stopped),
      .edge_count  (edge_count)
   );

   always #5 clk = ~clk;

   // mon_clk generator: rises at phase 0, settings reloaded at each rise.
   always @(negedge clk) begin
      if (!mon_run) begin
         mon_clk = 1'b0;
         phase   = 0;
      end else begin
         if (phase == 0) begin
            cur_per = mon_per;
            cur_hi  = mon_hi;
         end
         mon_clk = (phase < cur_hi);
         phase   = (phase + 1 >= cur_per) ? 0 : phase + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next period_vld pulse, bounded at 40 cycles.
   task automatic wait_vld(input string tag, output int cycles);
      cycles = 0;
      do begin
         tick(1);
         cycles++;
      end while ((period_vld !== 1'b1) && (cycles < 40));
      n_vec++;
      assert (period_vld === 1'b1) else begin
         n_err++;
         $error("FAIL %s: period_vld observed 0 expected 1 within 40 cycles", tag);
      end
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst_period",      32'(period), 0);
      check("rst_period_vld",  32'(period_vld), 0);
      check("rst_high_time",   32'(high_time), 0);
      check("rst_locked",      32'(locked), 0);
      check("rst_errs",        32'({err_range, err_stopped}), 0);
      check("rst_edge_count",  edge_count, 0);

      // 1: 4-cycle mon_clk, window [3,5]; lock after four reported periods
      rst_n   = 1'b1;
      enable  = 1'b1;
      mon_run = 1'b1;
      wait_vld("t1_vld1", cyc);
      check("t1_period1", 32'(period), 4);
      wait_vld("t1_vld2", cyc);
      check("t1_spacing", 32'(cyc), 4);
      wait_vld("t1_vld3", cyc);
      check("t1_unlocked_at_3", 32'(locked), 0);
      wait_vld("t1_vld4", cyc);
      check("t1_locked_at_4", 32'(locked), 1);
      check("t1_high_time", 32'(high_time), 32'(HT50));
      check("t1_edge_count", edge_count, 4);
      tick(1);
      check("t1_vld_pulse", 32'(period_vld), 0);

      // 2: switch to 8 cycles; one more 4-cycle period, then 8 out of range
      mon_per = 8;
      mon_hi  = 4;
      wait_vld("t2_vld5", cyc);
      check("t2_old_period", 32'(period), 4);
      wait_vld("t2_vld6", cyc);
      check("t2_period8", 32'(period), 8);
      check("t2_err_range", 32'(err_range), 1);
      check("t2_lock_lost", 32'(locked), 0);
      check("t2_edge_count", edge_count, 6);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      check("t2_cleared", 32'(err_range), 0);
      check("t2_still_unlocked", 32'(locked), 0);

      // clear_err coincident with a new range error: the error wins
      tick(6);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      check("t5_collide_vld", 32'(period_vld), 1);
      check("t5_error_wins", 32'(err_range), 1);
      check("t5_edge_count", edge_count, 7);

      // 3: stop mon_clk; err_stopped exactly 1000 cycles after the last reported rise
      mon_run = 1'b0;
      tick(999);
      check("t3_not_yet_stopped", 32'(err_stopped), 0);
      tick(1);
      check("t3_stopped", 32'(err_stopped), 1);
      check("t3_unlocked", 32'(locked), 0);
      mon_per = 4;
      mon_hi  = 2;
      mon_run = 1'b1;
      wait_vld("t3_rvld1", cyc);
      check("t3_restart_period", 32'(period), 4);
      wait_vld("t3_rvld2", cyc);
      wait_vld("t3_rvld3", cyc);
      wait_vld("t3_rvld4", cyc);
      check("t3_relocked", 32'(locked), 1);
      check("t3_stopped_sticky", 32'(err_stopped), 1);
      check("t3_edge_count", edge_count, 11);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      check("t3_cleared", 32'({err_range, err_stopped}), 0);

      // 5: enable low while locked -> unlocked next cycle, outputs hold
      enable = 1'b0;
      tick(1);
      check("t5_unlock", 32'(locked), 0);
      check("t5_period_hold", 32'(period), 4);
      check("t5_edge_hold", edge_count, 11);
      tick(2);
      enable = 1'b1;
      tick(1);
      check("t5_edge_restart", edge_count, 0);

      // Inclusive window [4,4], then an inverted window [5,3]
      min_period = 16'd4;
      max_period = 16'd4;
      wait_vld("bnd_vld1", cyc);
      check("bnd_inclusive", 32'(err_range), 0);
      check("bnd_first_after_arm", edge_count, 1);
      min_period = 16'd5;
      max_period = 16'd3;
      wait_vld("bnd_vld2", cyc);
      check("bnd_inverted", 32'(err_range), 1);
      check("bnd_inverted_unlock", 32'(locked), 0);
      min_period = 16'd3;
      max_period = 16'd5;
      clear_err  = 1'b1;
      tick(1);
      clear_err  = 1'b0;

      // 6: 25% duty
      mon_hi = 1;
      wait_vld("t6_vld1", cyc);
      wait_vld("t6_vld2", cyc);
      check("t6_high_time", 32'(high_time), 32'(HT25));
      wait_vld("t6_vld3", cyc);
      wait_vld("t6_vld4", cyc);
      check("t6_locked", 32'(locked), 1);

      // 4: asynchronous reset mid-lock clears everything immediately
      rst_n   = 1'b0;
      mon_run = 1'b0;
      #2;
      check("t4_period", 32'(period), 0);
      check("t4_high_time", 32'(high_time), 0);
      check("t4_locked", 32'(locked), 0);
      check("t4_edge_count", edge_count, 0);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      mon_run = 1'b1;
      wait_vld("t4_vld", cyc);
      check("t4_first_rise_skipped", 32'(cyc), 7);
      check("t4_period_after", 32'(period), 4);
      check("t4_edge_after", edge_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
